// File: rtl/arb_mux_2_1.sv
// arb_mux_2_1: registered two-input valid/ready stream arbiter.
// Picks one winner per beat and latches it into a single-entry output
// register. The held beat's source is exported on `select` so the 2:1
// multiplexer stage downstream can observe which channel won.
//
// Build option: define ARB_FIXED_PRIO_EN for strict fixed priority
// (A always wins contention, no last_grant state). Left undefined, the
// arbiter rotates round-robin between A and B.
module arb_mux_2_1 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              y_valid,
    output logic [DATA_W-1:0] y_data,
    input  logic              y_ready,
    output logic              select
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] y_data_q, y_data_d;
    logic              select_q, select_d;
    logic              accept;
    logic              grant_a, grant_b;
    logic              transfer;

`ifndef ARB_FIXED_PRIO_EN
    // 0 = A won the most recent transfer, 1 = B. Resets to 1 so A wins first.
    logic              last_grant_q, last_grant_d;
`endif

    // Output register can take a new beat when empty or when it drains this cycle
    always_comb begin
        accept = (state_q == EMPTY) || y_ready;
    end

    // Grant decision; never grants a channel that is not valid
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (a_valid && b_valid) begin
`ifdef ARB_FIXED_PRIO_EN
            grant_a = 1'b1;
`else
            // Serve the channel that did not win last time
            grant_a = last_grant_q;
            grant_b = ~last_grant_q;
`endif
        end else begin
            grant_a = a_valid;
            grant_b = b_valid;
        end
    end

    // A transfer moves the granted beat into the output register; blocked in reset
    always_comb begin
        transfer = !rst && accept && (grant_a || grant_b);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; FULL -> FULL on drain-and-fill keeps full throughput
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (transfer) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (y_ready && !transfer) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // FSM outputs; readies are forced low during reset
    always_comb begin
        y_valid = (state_q == FULL);
        a_ready = !rst && accept && grant_a;
        b_ready = !rst && accept && grant_b;
    end

    // Next value of the held beat: load winner on transfer, otherwise hold
    always_comb begin
        y_data_d = y_data_q;
        select_d = select_q;
        if (transfer) begin
            y_data_d = grant_b ? b_data : a_data;
            select_d = grant_b;
        end
    end

    // Held beat register
    always_ff @(posedge clk) begin
        if (rst) begin
            y_data_q <= '0;
            select_q <= 1'b0;
        end else begin
            y_data_q <= y_data_d;
            select_q <= select_d;
        end
    end

`ifndef ARB_FIXED_PRIO_EN
    // Priority only rotates on an actual transfer, never on idle cycles
    always_comb begin
        last_grant_d = last_grant_q;
        if (transfer) begin
            last_grant_d = grant_b;
        end
    end

    // Round-robin history register
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign y_data = y_data_q;
    assign select = select_q;

endmodule

// File: tb/tb_arb_mux_2_1.sv
module tb_arb_mux_2_1;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              a_valid;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              y_valid;
    logic [DATA_W-1:0] y_data;
    logic              y_ready;
    logic              select;

    int vectors     = 0;
    int miscompares = 0;

    arb_mux_2_1 #(.DATA_W(DATA_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_ready (b_ready),
        .y_valid (y_valid),
        .y_data  (y_data),
        .y_ready (y_ready),
        .select  (select)
    );

    always #5 clk = ~clk;

`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_data  = '0;
        b_data  = '0;
        y_ready = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        idle_inputs();
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        // Hold rst high while A requests: no ready, nothing captured
        rst = 1'b1;
        idle_inputs();
        a_valid = 1'b1;
        a_data  = 8'hC3;
        y_ready = 1'b1;
        #1;
        vectors++;
        if (a_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_a_ready: got %b want 0", a_ready);
        end
        tick();
        tick();
        vectors++;
        if (y_valid !== 1'b0 || select !== 1'b0 || y_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b sel=%b d=%h want v=0 sel=0 d=00", y_valid, select, y_data);
        end
        rst = 1'b0;
        a_data = 8'h5A;
        #1;
        vectors++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL single_ready: got a=%b b=%b want a=1 b=0", a_ready, b_ready);
        end
        tick();
        a_valid = 1'b0;
        vectors++;
        if (y_valid !== 1'b1 || y_data !== 8'h5A || select !== 1'b0) begin
            miscompares++;
            $display("FAIL single_beat: got v=%b d=%h sel=%b want v=1 d=5a sel=0", y_valid, y_data, select);
        end
        tick();
        vectors++;
        if (y_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_drain: got v=%b want 0", y_valid);
        end
    endtask

    task automatic test_contention();
        logic [7:0] exp_d;
        logic       exp_s;
        do_reset(2);
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data  = 8'h11;
        b_data  = 8'h22;
        y_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_s = FIXED ? 1'b0 : i[0];
            exp_d = exp_s ? 8'h22 : 8'h11;
            #1;
            vectors++;
            if (a_ready !== ~exp_s || b_ready !== exp_s) begin
                miscompares++;
                $display("FAIL contention_ready[%0d]: got a=%b b=%b want a=%b b=%b", i, a_ready, b_ready, ~exp_s, exp_s);
            end
            tick();
            vectors++;
            if (y_valid !== 1'b1 || y_data !== exp_d || select !== exp_s) begin
                miscompares++;
                $display("FAIL contention_out[%0d]: got v=%b d=%h sel=%b want v=1 d=%h sel=%b", i, y_valid, y_data, select, exp_d, exp_s);
            end
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset(1);
        a_valid = 1'b1;
        a_data  = 8'h33;
        y_ready = 1'b0;
        tick();
        a_valid = 1'b0;
        b_valid = 1'b1;
        b_data  = 8'h44;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (b_ready !== 1'b0 || a_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_ready[%0d]: got a=%b b=%b want 0 0", i, a_ready, b_ready);
            end
            tick();
            vectors++;
            if (y_valid !== 1'b1 || y_data !== 8'h33 || select !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h sel=%b want v=1 d=33 sel=0", i, y_valid, y_data, select);
            end
        end
        y_ready = 1'b1;
        #1;
        vectors++;
        if (b_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release_ready: got %b want 1", b_ready);
        end
        tick();
        b_valid = 1'b0;
        vectors++;
        if (y_valid !== 1'b1 || y_data !== 8'h44 || select !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release_out: got v=%b d=%h sel=%b want v=1 d=44 sel=1", y_valid, y_data, select);
        end
        tick();
    endtask

    task automatic test_single_requester();
        logic [7:0] d;
        do_reset(1);
        y_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            d = 8'(i);
            b_valid = 1'b1;
            b_data  = d;
            #1;
            vectors++;
            if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL single_b_ready[%0d]: got a=%b b=%b want a=0 b=1", i, a_ready, b_ready);
            end
            tick();
            vectors++;
            if (y_valid !== 1'b1 || y_data !== d || select !== 1'b1) begin
                miscompares++;
                $display("FAIL single_b_out[%0d]: got v=%b d=%h sel=%b want v=1 d=%h sel=1", i, y_valid, y_data, select, d);
            end
        end
        b_valid = 1'b0;
        a_valid = 1'b1;
        a_data  = 8'h77;
        #1;
        vectors++;
        if (a_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL switch_a_ready: got %b want 1", a_ready);
        end
        tick();
        a_valid = 1'b0;
        vectors++;
        if (y_valid !== 1'b1 || y_data !== 8'h77 || select !== 1'b0) begin
            miscompares++;
            $display("FAIL switch_a_out: got v=%b d=%h sel=%b want v=1 d=77 sel=0", y_valid, y_data, select);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset(1);
        a_valid = 1'b1;
        a_data  = 8'hAA;
        y_ready = 1'b0;
        tick();
        a_valid = 1'b0;
        vectors++;
        if (y_valid !== 1'b1 || y_data !== 8'hAA) begin
            miscompares++;
            $display("FAIL mid_setup: got v=%b d=%h want v=1 d=aa", y_valid, y_data);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        y_ready = 1'b1;
        vectors++;
        if (y_valid !== 1'b0 || select !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_state: got v=%b sel=%b want v=0 sel=0", y_valid, select);
        end
        tick();
        vectors++;
        if (y_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_no_ghost: got v=%b d=%h want v=0", y_valid, y_data);
        end
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data  = 8'h11;
        b_data  = 8'h22;
        #1;
        vectors++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_first_grant: got a=%b b=%b want a=1 b=0", a_ready, b_ready);
        end
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        vectors++;
        if (y_data !== 8'h11 || select !== 1'b0 || y_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_first_out: got v=%b d=%h sel=%b want v=1 d=11 sel=0", y_valid, y_data, select);
        end
        tick();
    endtask

    // Random y_ready / valid pattern against a transaction-level model:
    // accepted beats go into a FIFO and must leave the output in the same order.
    task automatic test_random();
        logic [8:0] sb[$];
        logic [8:0] head;
        bit         m_full;
        bit         m_last;
        bit         ea, eb, acc;
        int         errs_before;
        do_reset(1);
        m_full = 1'b0;
        m_last = 1'b1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data  = 8'($urandom);
        b_data  = 8'($urandom);
        for (int cyc = 0; cyc < 400; cyc++) begin
            y_ready = ($urandom_range(0, 99) < 60);
            #1;
            errs_before = miscompares;
            vectors++;
            if (y_valid !== m_full) begin
                miscompares++;
                $display("FAIL rnd_valid[%0d]: got %b want %b", cyc, y_valid, m_full);
            end
            if (m_full && y_ready) begin
                head = sb.pop_front();
                vectors++;
                if (y_data !== head[7:0] || select !== head[8]) begin
                    miscompares++;
                    $display("FAIL rnd_beat[%0d]: got d=%h sel=%b want d=%h sel=%b", cyc, y_data, select, head[7:0], head[8]);
                end
            end
            acc = !m_full || y_ready;
            ea = 1'b0;
            eb = 1'b0;
            if (acc) begin
                if (a_valid && b_valid) begin
                    if (FIXED || m_last) ea = 1'b1;
                    else                 eb = 1'b1;
                end else begin
                    ea = a_valid;
                    eb = b_valid;
                end
            end
            vectors++;
            if (a_ready !== ea || b_ready !== eb) begin
                miscompares++;
                $display("FAIL rnd_ready[%0d]: got a=%b b=%b want a=%b b=%b", cyc, a_ready, b_ready, ea, eb);
            end
            if (ea) begin
                sb.push_back({1'b0, a_data});
                m_last = 1'b0;
            end else if (eb) begin
                sb.push_back({1'b1, b_data});
                m_last = 1'b1;
            end
            m_full = (ea || eb) ? 1'b1 : (y_ready ? 1'b0 : m_full);
            tick();
            if (miscompares > errs_before + 20) break;
            // Protocol: a pending beat stays put; a consumed one may be replaced
            if (ea || !a_valid) begin
                a_valid = ($urandom_range(0, 99) < 85);
                a_data  = 8'($urandom);
            end
            if (eb || !b_valid) begin
                b_valid = ($urandom_range(0, 99) < 85);
                b_data  = 8'($urandom);
            end
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        y_ready = 1'b1;
        #1;
        if (m_full) begin
            head = sb.pop_front();
            vectors++;
            if (y_valid !== 1'b1 || y_data !== head[7:0] || select !== head[8]) begin
                miscompares++;
                $display("FAIL rnd_final: got v=%b d=%h sel=%b want v=1 d=%h sel=%b", y_valid, y_data, select, head[7:0], head[8]);
            end
        end
        tick();
        vectors++;
        if (y_valid !== 1'b0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL rnd_drain: got v=%b left=%0d want v=0 left=0", y_valid, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_backpressure();
        test_single_requester();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arb_mux_2_1.md
Name: arb_mux_2_1

Overview:
- Registered two-input stream arbiter that drives the select of the 2:1 multiplexer stage and forwards the winning channel's data.
- Sits directly upstream of the 2:1 multiplexer datapath.
- Each input is a valid/ready channel. The arbiter picks one winner per beat, round-robin, and latches it into a single-entry output register with its own valid/ready handshake.
- Also exports the source of the held beat, so the downstream stage can observe which channel was selected.

Parameters:
- DATA_W, 8, width of each input channel and of the output data.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- a_valid  input  1  channel A has a beat.
- a_data  input  DATA_W  channel A payload.
- a_ready  output  1  channel A beat accepted this cycle.
- b_valid  input  1  channel B has a beat.
- b_data  input  DATA_W  channel B payload.
- b_ready  output  1  channel B beat accepted this cycle.
- y_valid  output  1  output register holds a beat.
- y_data  output  DATA_W  held payload.
- y_ready  input  1  downstream accepts the held beat.
- select  output  1  source of held beat: 0 = A, 1 = B.

Behaviour:
- One clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - y_valid = 0, y_data = 0, select = 0.
  - last_grant = 1, so A wins the first contention.
  - a_ready = b_ready = 0 while rst is high.
- State machine:
  - EMPTY: y_valid = 0.
  - FULL: y_valid = 1.
- accept = (state == EMPTY) || y_ready. This is combinational, with no combinational path from y_ready other than through accept.
- Grant, evaluated combinationally each cycle:
  - Only a_valid: grant A.
  - Only b_valid: grant B.
  - Both valid: grant the channel not equal to last_grant.
  - Neither valid: no grant.
- a_ready = accept && grant_A. b_ready = accept && grant_B. Ready is never asserted for a channel that is not valid.
- On a transfer (accept and a grant):
  - Next cycle y_data = winning data, select = winning index, y_valid = 1, last_grant = winning index.
  - Latency: input beat to y_valid is 1 cycle.
- Transitions:
  - EMPTY -> FULL on a transfer.
  - FULL -> EMPTY when y_ready is high and there is no grant.
  - FULL -> FULL when y_ready is high and there is a grant: back-to-back beats at full throughput with no bubble.
  - FULL with y_ready low: hold. y_data and select stay stable, a_ready = b_ready = 0.
- Simultaneous drain and fill in the same cycle is legal and required.
- last_grant changes only on a transfer. Idle cycles do not rotate priority.
- Inputs are assumed to follow the protocol: valid and data stable until ready. No data is dropped or duplicated under any y_ready pattern.
- If rst is asserted mid-operation, the held beat is discarded and all outputs return to their reset values on the next edge.
- y_data and select are don't-care when y_valid = 0, but must not change while y_valid = 1 and y_ready = 0.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined:
  - The arbiter is strict fixed-priority: A always wins when both are valid.
  - last_grant is not implemented.
  - B is served only when a_valid = 0.
- Undefined (default): round-robin as described in Behaviour.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset then single beat: rst high 2 cycles. Check y_valid = 0 and select = 0. Then a_valid = 1, a_data = 8'h5A for 1 cycle with y_ready = 1. Required: next cycle y_valid = 1, y_data = 8'h5A, select = 0.
2. Contention round-robin: a_valid = b_valid = 1 continuously, a_data = 8'h11, b_data = 8'h22, y_ready = 1. Required: output sequence 11, 22, 11, 22 with select 0, 1, 0, 1, one beat per cycle, no bubbles.
   - With ARB_FIXED_PRIO_EN defined: output is 11 every cycle and b_ready never asserts.
3. Backpressure: output FULL with y_data = 8'h33, y_ready = 0 for 4 cycles while b_valid = 1, b_data = 8'h44. Required: y_data stays 33 and b_ready = 0 throughout. Then y_ready = 1 gives 44 on the next cycle.
4. Single requester: only b_valid = 1 for 3 beats, data 8'h01, 8'h02, 8'h03, y_ready = 1. Required: all 3 beats appear in order with select = 1. Then assert A alone: A is granted immediately with no waiting cycle.
5. Reset mid-operation: FULL with y_data = 8'hAA, y_ready = 0, then rst = 1 for 1 cycle. Required: y_valid = 0 next cycle and 8'hAA never appears. The next contention grants A first.
6. Randomised y_ready with both channels valid: a scoreboard confirms every accepted beat appears exactly once, in acceptance order, with the correct select.
